// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state type and baud divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Rounded clk cycles per bit
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, resets to 1 to match an idle-high line
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with byte strobe and framing-error pulse
// Optional macro SERIAL_RX_FRAME_CHECK_EN: discard frames whose stop bit is low.
module serial_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       flag,
    output logic [7:0] received_char,
    output logic       frame_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);

    rx_state_t     state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    char_next;
    logic          flag_next, err_next;
    logic          rxd_s;
    logic          timer_zero;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign timer_zero = (timer == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            received_char <= 8'h00;
            flag          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            bit_idx       <= bit_idx_next;
            shift         <= shift_next;
            received_char <= char_next;
            flag          <= flag_next;
            frame_err     <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        char_next    = received_char;
        flag_next    = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    timer_next = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                // Re-check mid start bit so short glitches are ignored
                if (timer_zero) begin
                    if (rxd_s) begin
                        state_next = IDLE;
                    end else begin
                        timer_next   = FULL_LOAD;
                        bit_idx_next = 3'd0;
                        state_next   = DATA;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            DATA: begin
                if (timer_zero) begin
                    shift_next   = {rxd_s, shift[7:1]};
                    timer_next   = FULL_LOAD;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed
                if (timer_zero) begin
                    if (rxd_s) begin
                        char_next  = shift;
                        flag_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
`ifdef SERIAL_RX_FRAME_CHECK_EN
                        char_next  = received_char;
`else
                        char_next  = shift;
                        flag_next  = 1'b1;
`endif
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized scoreboard bench for serial_rx
module tb_serial_rx;
    import uart_pkg::*;

    localparam int BIT_CYC = 16;
    localparam int LAT     = 2 + BIT_CYC / 2 + 9 * BIT_CYC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       flag;
    logic [7:0] received_char;
    logic       frame_err;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         has_flag;
        bit         has_err;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fails = 0;
    int         flag_count = 0;
    logic [7:0] model_char = 8'h00;

    serial_rx #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .flag          (flag),
        .received_char (received_char),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the oldest expected frame outcome
    always @(negedge clk) begin
        if (rst && (flag || frame_err)) begin
            ev_t e;
            int  lat;
            if (flag) flag_count++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_output: flag=%0b frame_err=%0b char=0x%0h at cycle %0d",
                         flag, frame_err, received_char, cyc);
            end else begin
                e = sb.pop_front();
                chk("flag", 32'(flag), 32'(e.has_flag));
                chk("frame_err", 32'(frame_err), 32'(e.has_err));
                if (e.has_flag) model_char = e.data;
                chk("received_char", 32'(received_char), 32'(model_char));
                lat = cyc - e.start;
                n_checks++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    n_fails++;
                    $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; callers enter 1 time unit after a rising edge
    task automatic send_frame(input logic [7:0] d, input bit bad);
        ev_t e;
        e.data  = d;
        e.start = cyc;
        e.has_err = bad;
`ifdef SERIAL_RX_FRAME_CHECK_EN
        e.has_flag = !bad;
`else
        e.has_flag = 1'b1;
`endif
        sb.push_back(e);
        rxd = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            idle(BIT_CYC);
        end
        if (!bad) begin
            rxd = 1'b1;
            idle(BIT_CYC);
        end else begin
            rxd = 1'b0;
            idle(2 * BIT_CYC);
            chk("wait_high_state", 32'(dut.state), 32'(WAIT_HIGH));
            idle(BIT_CYC);
            rxd = 1'b1;
            idle(BIT_CYC);
        end
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        idle(5);
        rst = 1'b1;
        chk("reset_flag", 32'(flag), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_char", 32'(received_char), 32'h00);
        idle(1000);
        chk("quiet_flags", 32'(flag_count), 32'd0);

        send_frame(8'hA5, 1'b0);
        idle(10);

        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        idle(10);

        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        chk("glitch_idle_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h3C, 1'b0);
        idle(10);

        send_frame(8'h55, 1'b1);
        idle(10);

        // Abort a frame with reset during data bit 4
        rxd = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            idle(BIT_CYC);
        end
        rxd = 1'b1;
        idle(8);
        rst = 1'b0;
        idle(2);
        chk("midreset_flag", 32'(flag), 32'd0);
        chk("midreset_frame_err", 32'(frame_err), 32'd0);
        chk("midreset_char", 32'(received_char), 32'h00);
        chk("midreset_state", 32'(dut.state), 32'(IDLE));
        model_char = 8'h00;
        rst = 1'b1;
        idle(40);
        send_frame(8'h81, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         bad;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, bad);
            idle($urandom_range(0, 20));
        end

        for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        idle(50);
        chk("char_held", 32'(received_char), 32'(model_char));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
